mips_instr_encoder: RTL and testbench

Streaming MIPS instruction encoder: accepts symbolic instruction requests (operation code plus register and immediate fields) and emits 32-bit MIPS machine words over a valid/ready stream. It covers the same instruction subset the core's control decoder recognises (addu, subu, jr, ori, lw, sw, beq, lui, jal, j, nop), plus the pseudo-instruction `li`, which expands to one or two words. It sits in the test and boot infrastructure and feeds instruction memory loaders and self-checking benches.

---
 rtl/mips_instr_encoder.sv | 258 +++++++++++++++++++++++++
 tb/tb_mips_instr_encoder.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_instr_encoder.sv
// -----------------------------------------------------------------------------
// mips_instr_encoder
//
// Streaming MIPS instruction encoder. A symbolic request (operation code plus
// register and immediate fields) goes in over a valid/ready handshake. The
// matching 32-bit machine word comes out over a second valid/ready stream.
// The pseudo-instruction LI is expanded to one or two words (LUI and/or ORI).
// Illegal operation codes are consumed without producing a word. They pulse
// err and bump a saturating error counter.
//
// Ports
//   clk        in   1   sole clock, rising edge
//   reset      in   1   synchronous, active-low
//   in_valid   in   1   request present
//   in_ready   out  1   request accepted this cycle when in_valid is also high
//   in_op      in   4   0 NOP, 1 ADDU, 2 SUBU, 3 JR, 4 ORI, 5 LW, 6 SW,
//                       7 BEQ, 8 LUI, 9 JAL, 10 J, 11 LI, 12-15 illegal
//   in_rs      in   5   source register field
//   in_rt      in   5   target register field
//   in_rd      in   5   destination register field
//   in_imm     in   32  immediate ([15:0], [25:0] or all 32 bits for LI)
//   out_valid  out  1   out_instr holds a word
//   out_ready  in   1   consumer takes the word
//   out_instr  out  32  encoded machine word
//   err        out  1   one-cycle pulse after an illegal op is accepted
//   err_cnt    out  8   illegal-op count, saturates at 255
//   word_cnt   out  16  output handshake count, wraps modulo 2^16
// -----------------------------------------------------------------------------
module mips_instr_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        err,
  output logic [7:0]  err_cnt,
  output logic [15:0] word_cnt
);

  // Request operation codes.
  localparam logic [3:0] REQ_NOP  = 4'd0;
  localparam logic [3:0] REQ_ADDU = 4'd1;
  localparam logic [3:0] REQ_SUBU = 4'd2;
  localparam logic [3:0] REQ_JR   = 4'd3;
  localparam logic [3:0] REQ_ORI  = 4'd4;
  localparam logic [3:0] REQ_LW   = 4'd5;
  localparam logic [3:0] REQ_SW   = 4'd6;
  localparam logic [3:0] REQ_BEQ  = 4'd7;
  localparam logic [3:0] REQ_LUI  = 4'd8;
  localparam logic [3:0] REQ_JAL  = 4'd9;
  localparam logic [3:0] REQ_J    = 4'd10;
  localparam logic [3:0] REQ_LI   = 4'd11;

  // MIPS primary opcodes.
  localparam logic [5:0] OPC_SPECIAL = 6'b000000;
  localparam logic [5:0] OPC_J       = 6'b000010;
  localparam logic [5:0] OPC_JAL     = 6'b000011;
  localparam logic [5:0] OPC_BEQ     = 6'b000100;
  localparam logic [5:0] OPC_ORI     = 6'b001101;
  localparam logic [5:0] OPC_LUI     = 6'b001111;
  localparam logic [5:0] OPC_LW      = 6'b100011;
  localparam logic [5:0] OPC_SW      = 6'b101011;

  // SPECIAL function codes.
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;

  typedef enum logic {
    S_IDLE   = 1'b0,  // ready for a new request once the output slot frees
    S_SECOND = 1'b1   // LUI half of a two-word LI is on the output
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic        r_out_valid;
  logic [31:0] r_out_instr;
  logic        r_err;
  logic [7:0]  r_err_cnt;
  logic [15:0] r_word_cnt;
  logic [4:0]  r_li_rt;   // rt of the pending ORI half of LI
  logic [15:0] r_li_lo;   // imm[15:0] of the pending ORI half of LI

  logic        w_in_ready;
  logic        w_accept;
  logic        w_handshake;

  logic [31:0] w_first_word;
  logic        w_legal;
  logic        w_two_word;

  logic        w_load;
  logic [31:0] w_load_word;

  // ---------------------------------------------------------------------------
  // Handshake qualifiers
  // ---------------------------------------------------------------------------
  // A new request may only enter when the output slot is empty or drains this
  // same cycle. While the LUI half of LI is pending, the slot is spoken for.
  assign w_in_ready  = reset && (r_state == S_IDLE) && (!r_out_valid || out_ready);
  assign w_accept    = in_valid && w_in_ready;
  assign w_handshake = r_out_valid && out_ready;

  // ---------------------------------------------------------------------------
  // Request encoder: first (or only) word, legality and LI width
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of a combinational block gets a default up front, so
    // no path through the case leaves a value unassigned and infers a latch.
    w_first_word = '0;
    w_legal      = 1'b1;
    w_two_word   = 1'b0;

    unique case (in_op)
      REQ_NOP:  w_first_word = 32'h0000_0000;
      REQ_ADDU: w_first_word = {OPC_SPECIAL, in_rs, in_rt, in_rd, 5'b00000, FN_ADDU};
      REQ_SUBU: w_first_word = {OPC_SPECIAL, in_rs, in_rt, in_rd, 5'b00000, FN_SUBU};
      REQ_JR:   w_first_word = {OPC_SPECIAL, in_rs, 15'b0, FN_JR};
      REQ_ORI:  w_first_word = {OPC_ORI, in_rs, in_rt, in_imm[15:0]};
      REQ_LW:   w_first_word = {OPC_LW,  in_rs, in_rt, in_imm[15:0]};
      REQ_SW:   w_first_word = {OPC_SW,  in_rs, in_rt, in_imm[15:0]};
      REQ_BEQ:  w_first_word = {OPC_BEQ, in_rs, in_rt, in_imm[15:0]};
      REQ_LUI:  w_first_word = {OPC_LUI, 5'b00000, in_rt, in_imm[15:0]};
      REQ_JAL:  w_first_word = {OPC_JAL, in_imm[25:0]};
      REQ_J:    w_first_word = {OPC_J,   in_imm[25:0]};
      REQ_LI: begin
        if (in_imm[31:16] == 16'h0000) begin
          // Fits in 16 unsigned bits: ori rt,$0,lo
          w_first_word = {OPC_ORI, 5'b00000, in_rt, in_imm[15:0]};
        end else if (in_imm[15:0] == 16'h0000) begin
          // Low half empty: lui rt,hi alone is enough
          w_first_word = {OPC_LUI, 5'b00000, in_rt, in_imm[31:16]};
        end else begin
          // lui rt,hi now; ori rt,rt,lo follows from the captured fields
          w_first_word = {OPC_LUI, 5'b00000, in_rt, in_imm[31:16]};
          w_two_word   = 1'b1;
        end
      end
      default:  w_legal = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous: it is only looked at on the clock edge, so it
    // lives inside the clocked block rather than in the sensitivity list.
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept && w_legal && w_two_word) begin
          w_next_state = S_SECOND;
        end
      end
      S_SECOND: begin
        // The LUI word leaves on this handshake and the ORI word replaces it.
        if (out_ready) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic -- which word, if any, loads into the output slot
  // ---------------------------------------------------------------------------
  always_comb begin
    w_load      = 1'b0;
    w_load_word = '0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept && w_legal) begin
          w_load      = 1'b1;
          w_load_word = w_first_word;
        end
      end
      S_SECOND: begin
        if (out_ready) begin
          w_load      = 1'b1;
          w_load_word = {OPC_ORI, r_li_rt, r_li_rt, r_li_lo};
        end
      end
      default: begin
        w_load      = 1'b0;
        w_load_word = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output slot, LI capture and status counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: clocked state is updated with non-blocking assignments, so every
    // register here sees the pre-edge values of the others regardless of order.
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_out_instr <= '0;
      r_err       <= 1'b0;
      r_err_cnt   <= '0;
      r_word_cnt  <= '0;
      r_li_rt     <= '0;
      r_li_lo     <= '0;
    end else begin
      // A load wins over a drain, which keeps out_valid high across
      // back-to-back words. A drain with nothing new empties the slot.
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_instr <= w_load_word;
      end else if (w_handshake) begin
        r_out_valid <= 1'b0;
      end

      if (w_accept && w_legal && w_two_word) begin
        r_li_rt <= in_rt;
        r_li_lo <= in_imm[15:0];
      end

      r_err <= w_accept && !w_legal;
      if (w_accept && !w_legal && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end

      if (w_handshake) begin
        r_word_cnt <= r_word_cnt + 16'd1;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_instr = r_out_instr;
  assign err       = r_err;
  assign err_cnt   = r_err_cnt;
  assign word_cnt  = r_word_cnt;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_mips_instr_encoder
//
// Self-checking bench for mips_instr_encoder. The reference model is a queue
// of words still owed to the consumer. The head of the queue is what the
// output must show. Legal requests append their encoded words, and output
// handshakes pop the head. Readiness, err and both counters are derived from
// the queue and from plain integer counters.
// -----------------------------------------------------------------------------
module tb_mips_instr_encoder;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        err;
  logic [7:0]  err_cnt;
  logic [15:0] word_cnt;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model state
  logic [31:0] q[$];
  bit          m_err;
  int          m_err_cnt;
  int          m_word_cnt;

  mips_instr_encoder dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_rs     (in_rs),
    .in_rt     (in_rt),
    .in_rd     (in_rd),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .err       (err),
    .err_cnt   (err_cnt),
    .word_cnt  (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic bit m_in_ready();
    return reset && ((q.size() == 0) || ((q.size() == 1) && out_ready));
  endfunction

  // Appends the machine words for one request; returns 0 for an illegal op.
  function automatic bit push_words(input logic [3:0] op, input logic [4:0] rs,
                                    input logic [4:0] rt, input logic [4:0] rd,
                                    input logic [31:0] imm);
    logic [15:0] hi;
    logic [15:0] lo;
    hi = imm[31:16];
    lo = imm[15:0];
    case (op)
      4'd0:  q.push_back(32'h0);
      4'd1:  q.push_back({6'h00, rs, rt, rd, 5'd0, 6'h21});
      4'd2:  q.push_back({6'h00, rs, rt, rd, 5'd0, 6'h23});
      4'd3:  q.push_back({6'h00, rs, 15'd0, 6'h08});
      4'd4:  q.push_back({6'h0D, rs, rt, lo});
      4'd5:  q.push_back({6'h23, rs, rt, lo});
      4'd6:  q.push_back({6'h2B, rs, rt, lo});
      4'd7:  q.push_back({6'h04, rs, rt, lo});
      4'd8:  q.push_back({6'h0F, 5'd0, rt, lo});
      4'd9:  q.push_back({6'h03, imm[25:0]});
      4'd10: q.push_back({6'h02, imm[25:0]});
      4'd11: begin
        if (hi == 16'h0) begin
          q.push_back({6'h0D, 5'd0, rt, lo});
        end else if (lo == 16'h0) begin
          q.push_back({6'h0F, 5'd0, rt, hi});
        end else begin
          q.push_back({6'h0F, 5'd0, rt, hi});
          q.push_back({6'h0D, rt, rt, lo});
        end
      end
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  // Applies what the coming rising edge will do, given the current inputs.
  task automatic model_edge();
    bit acc;
    bit hs;
    if (!reset) begin
      q.delete();
      m_err      = 1'b0;
      m_err_cnt  = 0;
      m_word_cnt = 0;
    end else begin
      acc = in_valid && m_in_ready();
      hs  = (q.size() > 0) && out_ready;
      if (hs) begin
        void'(q.pop_front());
        m_word_cnt = (m_word_cnt + 1) % 65536;
      end
      m_err = 1'b0;
      if (acc) begin
        if (!push_words(in_op, in_rs, in_rt, in_rd, in_imm)) begin
          m_err = 1'b1;
          if (m_err_cnt < 255) m_err_cnt = m_err_cnt + 1;
        end
      end
    end
  endtask

  // One clock: model updates at the falling edge, DUT sampled 1 after rising.
  task automatic step();
    @(negedge clk);
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [31:0] imm);
    in_valid = 1'b1;
    in_op    = op;
    in_rs    = rs;
    in_rt    = rt;
    in_rd    = rd;
    in_imm   = imm;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_op    = 4'd0;
    in_rs    = 5'd0;
    in_rt    = 5'd0;
    in_rd    = 5'd0;
    in_imm   = 32'd0;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset     = 1'b0;
    out_ready = 1'b1;
    idle();
    step();
    step();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    vectors++; if (out_instr !== 32'h0) begin miscompares++; $display("FAIL reset_out_instr: got %h want 00000000", out_instr); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", err); end
    vectors++; if (err_cnt !== 8'd0) begin miscompares++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
    vectors++; if (word_cnt !== 16'd0) begin miscompares++; $display("FAIL reset_word_cnt: got %0d want 0", word_cnt); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    reset = 1'b1;
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_addu();
    out_ready = 1'b1;
    drive(4'd1, 5'd1, 5'd2, 5'd3, 32'h0);
    step();
    idle();
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL addu_valid: got %b want 1", out_valid); end
    vectors++; if (out_instr !== 32'h00221821) begin miscompares++; $display("FAIL addu_word: got %h want 00221821", out_instr); end
    vectors++; if (word_cnt !== 16'd0) begin miscompares++; $display("FAIL addu_cnt_before: got %0d want 0", word_cnt); end
    step();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL addu_drained: got %b want 0", out_valid); end
    vectors++; if (word_cnt !== 16'd1) begin miscompares++; $display("FAIL addu_cnt_after: got %0d want 1", word_cnt); end
  endtask

  task automatic test_li_two_word();
    out_ready = 1'b1;
    drive(4'd11, 5'd0, 5'd8, 5'd0, 32'h12345678);
    step();
    drive(4'd1, 5'd7, 5'd7, 5'd7, 32'h0);  // must not be taken during SECOND
    #1;
    vectors++; if (out_instr !== 32'h3C081234) begin miscompares++; $display("FAIL li_lui_word: got %h want 3C081234", out_instr); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL li_second_ready: got %b want 0", in_ready); end
    step();
    idle();
    #1;
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL li_ori_valid: got %b want 1", out_valid); end
    vectors++; if (out_instr !== 32'h35085678) begin miscompares++; $display("FAIL li_ori_word: got %h want 35085678", out_instr); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL li_after_ready: got %b want 1", in_ready); end
    step();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL li_drained: got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] base;
    out_ready = 1'b1;
    base = word_cnt;
    drive(4'd11, 5'd0, 5'd9, 5'd0, 32'h0000ABCD);
    step();
    vectors++; if (out_instr !== 32'h3409ABCD) begin miscompares++; $display("FAIL li_ori_only: got %h want 3409ABCD", out_instr); end
    drive(4'd9, 5'd0, 5'd0, 5'd0, 32'h0100004);
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready: got %b want 1", in_ready); end
    step();
    vectors++; if (out_instr !== 32'h0C100004) begin miscompares++; $display("FAIL jal_word: got %h want 0C100004", out_instr); end
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid: got %b want 1", out_valid); end
    vectors++; if (word_cnt !== base + 16'd1) begin miscompares++; $display("FAIL b2b_cnt: got %0d want %0d", word_cnt, base + 16'd1); end
    drive(4'd11, 5'd0, 5'd9, 5'd0, 32'hABCD0000);
    step();
    idle();
    vectors++; if (out_instr !== 32'h3C09ABCD) begin miscompares++; $display("FAIL li_lui_only: got %h want 3C09ABCD", out_instr); end
    step();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL li_lui_only_single: got %b want 0", out_valid); end
    vectors++; if (word_cnt !== base + 16'd3) begin miscompares++; $display("FAIL b2b_cnt_end: got %0d want %0d", word_cnt, base + 16'd3); end
  endtask

  task automatic test_backpressure();
    logic [15:0] base;
    base = word_cnt;
    out_ready = 1'b0;
    drive(4'd7, 5'd4, 5'd5, 5'd0, 32'h0000FFFF);
    step();
    idle();
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++; if (out_instr !== 32'h1085FFFF) begin miscompares++; $display("FAIL bp_word[%0d]: got %h want 1085FFFF", i, out_instr); end
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid[%0d]: got %b want 1", i, out_valid); end
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_ready[%0d]: got %b want 0", i, in_ready); end
      step();
    end
    out_ready = 1'b1;
    step();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_release: got %b want 0", out_valid); end
    vectors++; if (word_cnt !== base + 16'd1) begin miscompares++; $display("FAIL bp_one_hs: got %0d want %0d", word_cnt, base + 16'd1); end
    step();
    vectors++; if (word_cnt !== base + 16'd1) begin miscompares++; $display("FAIL bp_no_extra_hs: got %0d want %0d", word_cnt, base + 16'd1); end
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    drive(4'd13, 5'd1, 5'd1, 5'd1, 32'h0);
    step();
    idle();
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL illegal_err: got %b want 1", err); end
    vectors++; if (err_cnt !== 8'd1) begin miscompares++; $display("FAIL illegal_cnt: got %0d want 1", err_cnt); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL illegal_no_word: got %b want 0", out_valid); end
    step();
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL illegal_pulse_end: got %b want 0", err); end
    for (int i = 0; i < 256; i++) begin
      drive(4'(12 + (i % 4)), 5'd0, 5'd0, 5'd0, 32'h0);
      step();
    end
    idle();
    vectors++; if (err_cnt !== 8'd255) begin miscompares++; $display("FAIL err_cnt_sat: got %0d want 255", err_cnt); end
    step();
    vectors++; if (err_cnt !== 8'd255) begin miscompares++; $display("FAIL err_cnt_hold: got %0d want 255", err_cnt); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL illegal_stream_no_word: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_in_second();
    out_ready = 1'b1;
    drive(4'd11, 5'd0, 5'd8, 5'd0, 32'h12345678);
    step();
    idle();
    vectors++; if (out_instr !== 32'h3C081234) begin miscompares++; $display("FAIL rs_lui_word: got %h want 3C081234", out_instr); end
    reset = 1'b0;
    step();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rs_valid: got %b want 0", out_valid); end
    vectors++; if (word_cnt !== 16'd0) begin miscompares++; $display("FAIL rs_word_cnt: got %0d want 0", word_cnt); end
    vectors++; if (err_cnt !== 8'd0) begin miscompares++; $display("FAIL rs_err_cnt: got %0d want 0", err_cnt); end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rs_no_ori[%0d]: got %b/%h want 0", i, out_valid, out_instr); end
    end
  endtask

  task automatic test_random();
    logic [31:0] imm;
    logic [15:0] r16;
    for (int n = 0; n < 2000; n++) begin
      reset     = ($urandom_range(0, 199) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      in_op     = 4'($urandom_range(0, 15));
      in_rs     = 5'($urandom);
      in_rt     = 5'($urandom);
      in_rd     = 5'($urandom);
      imm       = $urandom;
      r16       = 16'($urandom);
      case ($urandom_range(0, 3))
        0: imm = {16'h0, r16};
        1: imm = {r16, 16'h0};
        default: ;
      endcase
      in_imm = imm;
      #1;
      vectors++; if (in_ready !== m_in_ready()) begin miscompares++; $display("FAIL rnd_in_ready[%0d]: got %b want %b", n, in_ready, m_in_ready()); end
      step();
      vectors++; if (out_valid !== (q.size() > 0)) begin miscompares++; $display("FAIL rnd_valid[%0d]: got %b want %b", n, out_valid, q.size() > 0); end
      if (q.size() > 0) begin
        vectors++; if (out_instr !== q[0]) begin miscompares++; $display("FAIL rnd_word[%0d]: got %h want %h", n, out_instr, q[0]); end
      end
      vectors++; if (err !== m_err) begin miscompares++; $display("FAIL rnd_err[%0d]: got %b want %b", n, err, m_err); end
      vectors++; if (err_cnt !== m_err_cnt[7:0]) begin miscompares++; $display("FAIL rnd_err_cnt[%0d]: got %0d want %0d", n, err_cnt, m_err_cnt); end
      vectors++; if (word_cnt !== m_word_cnt[15:0]) begin miscompares++; $display("FAIL rnd_word_cnt[%0d]: got %0d want %0d", n, word_cnt, m_word_cnt); end
    end
    reset = 1'b1;
    idle();
  endtask

  task automatic test_word_wrap();
    reset = 1'b0;
    idle();
    step();
    reset     = 1'b1;
    out_ready = 1'b1;
    drive(4'd0, 5'd0, 5'd0, 5'd0, 32'h0);
    // First cycle only accepts; each later cycle hands off one NOP and takes the next.
    for (int i = 0; i < 65536; i++) step();
    vectors++; if (word_cnt !== 16'hFFFF) begin miscompares++; $display("FAIL wrap_max: got %0d want 65535", word_cnt); end
    vectors++; if (word_cnt !== m_word_cnt[15:0]) begin miscompares++; $display("FAIL wrap_model: got %0d want %0d", word_cnt, m_word_cnt); end
    step();
    vectors++; if (word_cnt !== 16'h0000) begin miscompares++; $display("FAIL wrap_zero: got %0d want 0", word_cnt); end
    step();
    vectors++; if (word_cnt !== 16'h0001) begin miscompares++; $display("FAIL wrap_one: got %0d want 1", word_cnt); end
    idle();
  endtask

  initial begin
    reset     = 1'b0;
    out_ready = 1'b0;
    idle();
    test_reset();
    test_addu();
    test_li_two_word();
    test_back_to_back();
    test_backpressure();
    test_illegal();
    test_reset_in_second();
    test_random();
    test_word_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
